// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a small first-word-fall-through FIFO.
// rxd is synchronised, framed by a DIVISOR-cycle bit timer and centre-sampled.
// Good bytes are pushed into the FIFO, and the CPU pops them with a one-cycle rd strobe.
// Optional build macro UART_RX_PARITY_EN selects 8E1 framing with a PARITY state.
// When the macro is absent, parity_err is tied to 0. The port list is the same in both builds.
// Handshake: rx_ready=1 means data holds a valid head byte. A cycle with rd=1 and
// rx_ready=1 consumes that byte. rd while rx_ready=0 has no effect.
module uart_rx_fifo #(
    parameter int CLKSPEED  = 50000000,
    parameter int BAUD      = 115200,
    parameter int FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       rx_ready,
    output logic       rx_full,
    output logic       overrun,
    output logic       framing_err,
    output logic       parity_err
);
    localparam int DIVISOR = CLKSPEED / BAUD;
    localparam int CW      = $clog2(DIVISOR);
    localparam int DEPTH   = 1 << FIFO_LOG2;
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd3, S_BREAK = 3'd4, S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd3, S_BREAK = 3'd4
    } state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitn;
    logic [7:0]      shreg;
    logic            sync1, srx, srx_prev, armed;
    logic            tick, good_byte, frame_bad, push, pop;
    logic [FIFO_LOG2:0] wr_ptr, rd_ptr;
    logic [7:0]      mem [DEPTH];
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
    logic            par_event;
`endif

    // Two-flop synchroniser plus previous-sample copy for edge detection.
    // The flops reset low, so a line held low through reset never looks like an idle-to-start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            srx      <= 1'b0;
            srx_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync1    <= rxd;
            srx      <= sync1;
            srx_prev <= srx;
            armed    <= armed | srx;
        end
    end

    assign tick = (cnt == '0);
`ifdef UART_RX_PARITY_EN
    assign par_event = (state == S_PARITY) && tick && ((^shreg) ^ srx);
    assign good_byte = (state == S_STOP) && tick && srx && !par_bad;
`else
    assign good_byte = (state == S_STOP) && tick && srx;
`endif
    assign frame_bad = (state == S_STOP) && tick && !srx;

    // Frame FSM: bit timer counts down, and each bit is sampled on the cycle the timer reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (armed && srx_prev && !srx) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (!tick) begin
                        cnt <= cnt - CW'(1);
                    end else if (!srx) begin
                        state <= S_DATA;
                        cnt   <= FULL_LOAD;
                        bitn  <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {srx, shreg[7:1]};
                        cnt   <= FULL_LOAD;
                        if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!tick) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        par_bad <= (^shreg) ^ srx;
                        cnt     <= FULL_LOAD;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (!tick) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= srx ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (srx) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready = (wr_ptr != rd_ptr);
    assign rx_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    assign pop      = rd && rx_ready;
    assign push     = good_byte && (!rx_full || pop);
    assign data     = mem[rd_ptr[FIFO_LOG2-1:0]];

    // FIFO storage and pointers. A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr[FIFO_LOG2-1:0]] <= shreg;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky error flags: clr_err clears them, and a set event in the same cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            overrun     <= (overrun & ~clr_err) | (good_byte & rx_full & ~pop);
            framing_err <= (framing_err & ~clr_err) | frame_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, with the same clear and set rules as the other error flags.
    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= (parity_err & ~clr_err) | par_event;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIVISOR=16 (CLKSPEED=16, BAUD=1).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       rx_ready, rx_full, overrun, framing_err, parity_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKSPEED(16), .BAUD(1), .FIFO_LOG2(2)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rd(rd), .clr_err(clr_err),
        .data(data), .rx_ready(rx_ready), .rx_full(rx_full), .overrun(overrun),
        .framing_err(framing_err), .parity_err(parity_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic drive_bit(input logic v);
        @(negedge clk);
        rxd = v;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rxd = 1'b0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b, ^b);
        drive_bit(1'b1);
    endtask

    task automatic pulse_rd;
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
    endtask

    task automatic pop_expect(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check({tag, "_ready"}, {7'd0, rx_ready}, 8'd1);
        check({tag, "_data"}, data, e);
        pulse_rd();
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_ready", {7'd0, rx_ready}, 8'd0);
        check("rst_full", {7'd0, rx_full}, 8'd0);
        check("rst_data", data, 8'h00);
        check("rst_flags", {5'd0, overrun, framing_err, parity_err}, 8'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Test 1: 0xA5 with exact ready latency after the stop sample
        send_head(8'hA5, ^8'hA5);
        @(negedge clk); rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_ready_early", {7'd0, rx_ready}, 8'd0);
        @(negedge clk);
        check("t1_ready", {7'd0, rx_ready}, 8'd1);
        check("t1_data", data, 8'hA5);
        check("t1_flags", {5'd0, overrun, framing_err, parity_err}, 8'd0);
        repeat (4) @(negedge clk);
        pulse_rd();
        check("t1_ready_after_rd", {7'd0, rx_ready}, 8'd0);

        // Test 2: fill to full, then overrun
        for (int i = 1; i <= 3; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("t2_not_full_3", {7'd0, rx_full}, 8'd0);
        send_byte(8'h04);
        exp_q.push_back(8'h04);
        check("t2_full_4", {7'd0, rx_full}, 8'd1);
        check("t2_no_overrun_4", {7'd0, overrun}, 8'd0);
        send_byte(8'h05);
        check("t2_overrun_5", {7'd0, overrun}, 8'd1);
        check("t2_full_5", {7'd0, rx_full}, 8'd1);
        pop_expect("t2_pop1");
        check("t2_not_full_after_pop", {7'd0, rx_full}, 8'd0);
        pop_expect("t2_pop2");
        pop_expect("t2_pop3");
        pop_expect("t2_pop4");
        check("t2_empty", {7'd0, rx_ready}, 8'd0);
        check("t2_overrun_sticky", {7'd0, overrun}, 8'd1);
        pulse_clr();
        check("t2_overrun_clr", {7'd0, overrun}, 8'd0);

        // Test 3: 3-cycle low glitch
        @(negedge clk); rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_ready", {7'd0, rx_ready}, 8'd0);
        check("t3_framing", {7'd0, framing_err}, 8'd0);
        send_byte(8'hC3);
        exp_q.push_back(8'hC3);
        pop_expect("t3_after_glitch");

        // Test 4: stop bit low, long break, then a clean byte
        send_head(8'h3C, ^8'h3C);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        @(negedge clk); rxd = 1'b1;
        repeat (32) @(negedge clk);
        check("t4_framing", {7'd0, framing_err}, 8'd1);
        check("t4_empty", {7'd0, rx_ready}, 8'd0);
        check("t4_no_overrun", {7'd0, overrun}, 8'd0);
        send_byte(8'h55);
        exp_q.push_back(8'h55);
        pop_expect("t4_after_break");
        check("t4_empty_after_pop", {7'd0, rx_ready}, 8'd0);
        check("t4_framing_sticky", {7'd0, framing_err}, 8'd1);

        // Test 5: pop in the same cycle as a write into a full FIFO
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h66);
        check("t5_full", {7'd0, rx_full}, 8'd1);
        check("t5_head", data, 8'h11);
        send_head(8'h66, ^8'h66);
        @(negedge clk); rxd = 1'b1;
        repeat (10) @(negedge clk);
        rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        check("t5_no_overrun", {7'd0, overrun}, 8'd0);
        check("t5_still_full", {7'd0, rx_full}, 8'd1);
        check("t5_head_adv", data, 8'h22);
        repeat (4) @(negedge clk);
        pop_expect("t5_pop1");
        pop_expect("t5_pop2");
        pop_expect("t5_pop3");
        pop_expect("t5_pop4");
        check("t5_empty", {7'd0, rx_ready}, 8'd0);

        // Test 6: reset mid-frame with the line held low
        send_byte(8'h99);
        check("t6_pre_ready", {7'd0, rx_ready}, 8'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk); rxd = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready", {7'd0, rx_ready}, 8'd0);
        check("t6_full", {7'd0, rx_full}, 8'd0);
        check("t6_data", data, 8'h00);
        check("t6_flags", {5'd0, overrun, framing_err, parity_err}, 8'd0);
        repeat (300) @(negedge clk);
        check("t6_low_no_byte", {7'd0, rx_ready}, 8'd0);
        check("t6_low_no_err", {7'd0, framing_err}, 8'd0);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        send_byte(8'h5A);
        exp_q.push_back(8'h5A);
        pop_expect("t6_clean");

`ifdef UART_RX_PARITY_EN
        // Parity mismatch: 0x07 needs parity bit 1, so send 0
        send_head(8'h07, 1'b0);
        drive_bit(1'b1);
        check("tp_parity_err", {7'd0, parity_err}, 8'd1);
        check("tp_empty", {7'd0, rx_ready}, 8'd0);
        pulse_clr();
        check("tp_parity_clr", {7'd0, parity_err}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
